// File: rtl/mlblock_flex_mac_array.sv
// Tiled signed MAC array: config scan chain, cascaded weight chain, result cascade, selectable dataflow.
// Optional feature: define MLB_ACC_SAT_EN to saturate accumulation instead of wrapping.
module mlblock_flex_mac_array #(
    parameter int LANES     = 4,
    parameter int I_W       = 8,
    parameter int W_W       = 8,
    parameter int RES_W     = 32,
    parameter int ACC_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   config_en,
    input  logic                   config_in,
    output logic                   config_out,
    input  logic [LANES*I_W-1:0]   I_in,
    input  logic                   I_valid,
    input  logic [W_W-1:0]         W_in,
    input  logic                   W_en,
    output logic [W_W-1:0]         W_out,
    input  logic [LANES*RES_W-1:0] Res_cas_in,
    input  logic                   Res_cas_in_zero,
    output logic [LANES*RES_W-1:0] Res_out,
    output logic                   Res_valid,
    output logic [LANES*RES_W-1:0] Res_cas_out,
    output logic                   busy
);
    localparam int CONF_W = 2 + ACC_CNT_W;

    localparam logic [1:0] MODE_LANE  = 2'b00;
    localparam logic [1:0] MODE_RED   = 2'b01;
    localparam logic [1:0] MODE_BCAST = 2'b10;

    localparam logic [ACC_CNT_W-1:0] CNT_ZERO = {ACC_CNT_W{1'b0}};
    localparam logic [ACC_CNT_W-1:0] CNT_ONE  = {{(ACC_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [RES_W-1:0]     RES_ZERO = {RES_W{1'b0}};

    // Signed add of two RES_W values; one extra bit exposes overflow for clamping.
    function automatic logic [RES_W-1:0] acc_add(input logic [RES_W-1:0] a,
                                                 input logic [RES_W-1:0] b);
        logic [RES_W:0] sum;
        sum = {a[RES_W-1], a} + {b[RES_W-1], b};
`ifdef MLB_ACC_SAT_EN
        if (sum[RES_W] != sum[RES_W-1]) begin
            acc_add = sum[RES_W] ? {1'b1, {(RES_W-1){1'b0}}} : {1'b0, {(RES_W-1){1'b1}}};
        end else begin
            acc_add = sum[RES_W-1:0];
        end
`else
        acc_add = sum[RES_W-1:0];
`endif
    endfunction

    logic [CONF_W-1:0]          sr_r;
    logic                       cfg_en_d_r;
    logic [1:0]                 mode_r;
    logic [ACC_CNT_W-1:0]       acc_len_r;
    logic [W_W-1:0]             w_r [LANES];
    logic signed [RES_W-1:0]    i_ext_s [LANES];
    logic signed [RES_W-1:0]    w_ext_s [LANES];
    logic [RES_W-1:0]           lane_prod_s [LANES];
    logic [RES_W-1:0]           red_sum_s;
    logic [RES_W-1:0]           prod_s [LANES];
    logic [RES_W-1:0]           prod_r [LANES];
    logic [RES_W-1:0]           cas_s [LANES];
    logic [RES_W-1:0]           acc_nxt_s [LANES];
    logic [RES_W-1:0]           acc_r [LANES];
    logic [RES_W-1:0]           res_r [LANES];
    logic                       p_valid_r;
    logic                       p_first_r;
    logic                       p_last_r;
    logic                       res_valid_r;
    logic [ACC_CNT_W-1:0]       cnt_r;
    logic                       load_s;
    logic                       accept_s;
    logic                       last_beat_s;

    // Config takes effect on the falling edge of config_en; beats are blocked while it changes.
    assign load_s      = cfg_en_d_r & ~config_en;
    assign accept_s    = I_valid & ~config_en & ~load_s;
    assign last_beat_s = (cnt_r == acc_len_r);

    // Scan-chain shift register and active configuration
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_r       <= {CONF_W{1'b0}};
            cfg_en_d_r <= 1'b0;
            mode_r     <= MODE_LANE;
            acc_len_r  <= CNT_ZERO;
        end else begin
            cfg_en_d_r <= config_en;
            if (config_en) begin
                sr_r <= {sr_r[CONF_W-2:0], config_in};
            end
            if (load_s) begin
                mode_r    <= sr_r[CONF_W-1 -: 2];
                acc_len_r <= sr_r[ACC_CNT_W-1:0];
            end
        end
    end

    // Weight shift chain; lane LANES-1 cascades out to the next tile
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int l = 32'sd0; l < LANES; l++) begin
                w_r[l] <= {W_W{1'b0}};
            end
        end else if (W_en) begin
            w_r[0] <= W_in;
            for (int l = 32'sd1; l < LANES; l++) begin
                w_r[l] <= w_r[l-1];
            end
        end
    end

    // Sign-extended per-lane products and their reduction sum
    always_comb begin
        red_sum_s = RES_ZERO;
        for (int l = 32'sd0; l < LANES; l++) begin
            i_ext_s[l]     = RES_W'($signed(I_in[l*I_W +: I_W]));
            w_ext_s[l]     = RES_W'($signed(w_r[l]));
            lane_prod_s[l] = i_ext_s[l] * w_ext_s[l];
            red_sum_s      = red_sum_s + lane_prod_s[l];
        end
    end

    // Dataflow-mode product select; mode 11 falls back to per-lane
    always_comb begin
        for (int l = 32'sd0; l < LANES; l++) begin
            case (mode_r)
                MODE_LANE:  prod_s[l] = lane_prod_s[l];
                MODE_RED:   prod_s[l] = (l == 32'sd0) ? red_sum_s : RES_ZERO;
                MODE_BCAST: prod_s[l] = i_ext_s[0] * w_ext_s[l];
                default:    prod_s[l] = lane_prod_s[l];
            endcase
        end
    end

    // Product stage and window beat counter; a config load aborts the window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_valid_r <= 1'b0;
            p_first_r <= 1'b0;
            p_last_r  <= 1'b0;
            cnt_r     <= CNT_ZERO;
            for (int l = 32'sd0; l < LANES; l++) begin
                prod_r[l] <= RES_ZERO;
            end
        end else if (load_s) begin
            p_valid_r <= 1'b0;
            p_first_r <= 1'b0;
            p_last_r  <= 1'b0;
            cnt_r     <= CNT_ZERO;
        end else begin
            p_valid_r <= accept_s;
            if (accept_s) begin
                prod_r    <= prod_s;
                p_first_r <= (cnt_r == CNT_ZERO);
                p_last_r  <= last_beat_s;
                cnt_r     <= last_beat_s ? CNT_ZERO : cnt_r + CNT_ONE;
            end
        end
    end

    // Next accumulator value: first beat seeds from the cascade input
    always_comb begin
        for (int l = 32'sd0; l < LANES; l++) begin
            cas_s[l]     = Res_cas_in_zero ? RES_ZERO : Res_cas_in[l*RES_W +: RES_W];
            acc_nxt_s[l] = acc_add(p_first_r ? cas_s[l] : acc_r[l], prod_r[l]);
        end
    end

    // Accumulator and result registers with single-cycle valid strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid_r <= 1'b0;
            for (int l = 32'sd0; l < LANES; l++) begin
                acc_r[l] <= RES_ZERO;
                res_r[l] <= RES_ZERO;
            end
        end else begin
            res_valid_r <= 1'b0;
            if (p_valid_r && !load_s) begin
                acc_r <= acc_nxt_s;
                if (p_last_r) begin
                    res_r       <= acc_nxt_s;
                    res_valid_r <= 1'b1;
                end
            end
        end
    end

    // Flatten lane results onto the output buses
    always_comb begin
        for (int l = 32'sd0; l < LANES; l++) begin
            Res_out[l*RES_W +: RES_W] = res_r[l];
        end
    end

    assign Res_cas_out = Res_out;
    assign Res_valid   = res_valid_r;
    assign W_out       = w_r[LANES-1];
    assign config_out  = sr_r[CONF_W-1];
    assign busy        = (cnt_r != CNT_ZERO) | p_valid_r;

endmodule

// File: tb/tb_mlblock_flex_mac_array.sv
// Randomized self-checking bench for mlblock_flex_mac_array (default parameters) against a behavioural model.
module tb_mlblock_flex_mac_array;
    localparam int LN = 4;
    localparam int CW = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         config_en, config_in, config_out;
    logic [31:0]  I_in;
    logic         I_valid;
    logic [7:0]   W_in, W_out;
    logic         W_en;
    logic [127:0] Res_cas_in, Res_out, Res_cas_out;
    logic         Res_cas_in_zero, Res_valid, busy;

    int   total = 0;
    int   bad = 0;
    int   wt [LN];
    logic [1:0] mode_m;
    int   acclen_m;
    bit   cfg_q [$];

    mlblock_flex_mac_array dut (
        .clk(clk), .reset(reset), .config_en(config_en), .config_in(config_in),
        .config_out(config_out), .I_in(I_in), .I_valid(I_valid), .W_in(W_in),
        .W_en(W_en), .W_out(W_out), .Res_cas_in(Res_cas_in), .Res_cas_in_zero(Res_cas_in_zero),
        .Res_out(Res_out), .Res_valid(Res_valid), .Res_cas_out(Res_cas_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint add_m(input longint a, input longint b);
        longint s;
        s = a + b;
`ifdef MLB_ACC_SAT_EN
        if (s > 64'sd2147483647) return 64'sd2147483647;
        if (s < -64'sd2147483648) return -64'sd2147483648;
        return s;
`else
        return longint'(int'(s));
`endif
    endfunction

    function automatic longint exp_prod(input int l, input int iv[LN]);
        longint s;
        s = 0;
        case (mode_m)
            2'b01: if (l == 0) for (int k = 0; k < LN; k++) s += iv[k] * wt[k];
            2'b10: s = iv[0] * wt[l];
            default: s = iv[l] * wt[l];
        endcase
        return s;
    endfunction

    function automatic logic [31:0] pack_i(input int iv[LN]);
        logic [31:0] v;
        for (int l = 0; l < LN; l++) v[l*8 +: 8] = iv[l][7:0];
        return v;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < LN; l++) wt[l] = 0;
        mode_m = 2'b00;
        acclen_m = 0;
        cfg_q.delete();
        for (int k = 0; k < CW; k++) cfg_q.push_back(1'b0);
    endtask

    task automatic load_weights(input int v[LN]);
        for (int k = LN - 1; k >= 0; k--) begin
            W_en = 1'b1;
            W_in = v[k][7:0];
            for (int l = LN - 1; l > 0; l--) wt[l] = wt[l-1];
            wt[0] = int'($signed(v[k][7:0]));
            tick();
        end
        W_en = 1'b0;
    endtask

    task automatic configure(input logic [1:0] m, input int al);
        logic [CW-1:0] word;
        word = {m, al[7:0]};
        for (int k = CW - 1; k >= 0; k--) begin
            config_en = 1'b1;
            config_in = word[k];
            cfg_q.push_back(word[k]);
            tick();
        end
        config_en = 1'b0;
        config_in = 1'b0;
        tick();
        mode_m = m;
        acclen_m = al;
    endtask

    // Drives nb consecutive beats and returns the model's window result; ends one cycle after the last beat.
    task automatic run_window(input int nb, input bit rnd, input int ifix[LN], input bit cz,
                              input int cas[LN], output longint ex[LN]);
        int iv[LN];
        Res_cas_in_zero = cz;
        for (int l = 0; l < LN; l++) Res_cas_in[l*32 +: 32] = cas[l];
        for (int b = 0; b < nb; b++) begin
            for (int l = 0; l < LN; l++) iv[l] = rnd ? int'($urandom_range(255)) - 128 : ifix[l];
            I_in = pack_i(iv);
            I_valid = 1'b1;
            for (int l = 0; l < LN; l++)
                ex[l] = add_m((b == 0) ? (cz ? 64'sd0 : longint'(cas[l])) : ex[l], exp_prod(l, iv));
            tick();
        end
        I_valid = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (Res_out !== 128'd0) begin bad++; $display("FAIL rst_res: got %h want 0", Res_out); end
        total++; if (Res_cas_out !== 128'd0) begin bad++; $display("FAIL rst_cas: got %h want 0", Res_cas_out); end
        total++; if (Res_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", Res_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (W_out !== 8'd0) begin bad++; $display("FAIL rst_wout: got %h want 0", W_out); end
        total++; if (config_out !== 1'b0) begin bad++; $display("FAIL rst_cfgout: got %b want 0", config_out); end
    endtask

    task automatic test_mode00();
        longint ex[LN];
        int one[LN] = '{1, 1, 1, 1};
        int zc[LN] = '{0, 0, 0, 0};
        int rc[LN];
        load_weights('{1, 2, 3, 4});
        configure(2'b00, 2);
        run_window(3, 1'b0, one, 1'b1, zc, ex);
        total++; if (Res_valid !== 1'b0) begin bad++; $display("FAIL m00_early: got %b want 0", Res_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL m00_busy: got %b want 1", busy); end
        tick();
        total++; if (Res_valid !== 1'b1) begin bad++; $display("FAIL m00_valid: got %b want 1", Res_valid); end
        for (int l = 0; l < LN; l++) begin
            total++; if (Res_out[l*32 +: 32] !== 32'(3 * (l + 1))) begin bad++; $display("FAIL m00_res lane%0d: got %0d want %0d", l, Res_out[l*32 +: 32], 3 * (l + 1)); end
        end
        total++; if (Res_cas_out !== Res_out) begin bad++; $display("FAIL m00_cas_out: got %h want %h", Res_cas_out, Res_out); end
        tick();
        total++; if (Res_valid !== 1'b0) begin bad++; $display("FAIL m00_pulse: got %b want 0", Res_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL m00_idle: got %b want 0", busy); end
        for (int l = 0; l < LN; l++) rc[l] = int'($urandom);
        run_window(3, 1'b1, one, 1'b0, rc, ex);
        tick();
        total++; if (Res_valid !== 1'b1) begin bad++; $display("FAIL m00r_valid: got %b want 1", Res_valid); end
        for (int l = 0; l < LN; l++) begin
            total++; if (Res_out[l*32 +: 32] !== ex[l][31:0]) begin bad++; $display("FAIL m00r_res lane%0d: got %h want %h", l, Res_out[l*32 +: 32], ex[l][31:0]); end
        end
        tick(); tick();
        for (int l = 0; l < LN; l++) begin
            total++; if (Res_out[l*32 +: 32] !== ex[l][31:0]) begin bad++; $display("FAIL m00r_hold lane%0d: got %h want %h", l, Res_out[l*32 +: 32], ex[l][31:0]); end
        end
    endtask

    task automatic test_reset_mid_window();
        longint ex[LN];
        int rw[LN];
        int zc[LN] = '{0, 0, 0, 0};
        configure(2'b00, 3);
        I_in = $urandom; I_valid = 1'b1;
        tick();
        I_in = $urandom;
        #2 reset = 1'b0;
        #1;
        total++; if (Res_out !== 128'd0) begin bad++; $display("FAIL rmw_res: got %h want 0", Res_out); end
        total++; if (Res_valid !== 1'b0) begin bad++; $display("FAIL rmw_valid: got %b want 0", Res_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmw_busy: got %b want 0", busy); end
        I_valid = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        tick();
        for (int l = 0; l < LN; l++) rw[l] = int'($urandom_range(255)) - 128;
        load_weights(rw);
        configure(2'b00, 3);
        run_window(4, 1'b1, zc, 1'b1, zc, ex);
        tick();
        total++; if (Res_valid !== 1'b1) begin bad++; $display("FAIL rmw_fresh_valid: got %b want 1", Res_valid); end
        for (int l = 0; l < LN; l++) begin
            total++; if (Res_out[l*32 +: 32] !== ex[l][31:0]) begin bad++; $display("FAIL rmw_fresh lane%0d: got %h want %h", l, Res_out[l*32 +: 32], ex[l][31:0]); end
        end
        tick();
    endtask

    task automatic test_mode01();
        longint ex[LN];
        int five[LN] = '{5, 5, 5, 5};
        int c100[LN] = '{100, 0, 0, 0};
        int rc[LN];
        int rw[LN];
        load_weights('{1, -1, 2, -2});
        configure(2'b01, 0);
        run_window(1, 1'b0, five, 1'b0, c100, ex);
        tick();
        total++; if (Res_valid !== 1'b1) begin bad++; $display("FAIL m01_valid: got %b want 1", Res_valid); end
        for (int l = 0; l < LN; l++) begin
            total++; if (Res_out[l*32 +: 32] !== ((l == 0) ? 32'd100 : 32'd0)) begin bad++; $display("FAIL m01_res lane%0d: got %0d", l, Res_out[l*32 +: 32]); end
        end
        run_window(1, 1'b0, five, 1'b1, c100, ex);
        tick();
        total++; if (Res_out !== 128'd0) begin bad++; $display("FAIL m01_zero: got %h want 0", Res_out); end
        for (int l = 0; l < LN; l++) begin rw[l] = int'($urandom_range(255)) - 128; rc[l] = int'($urandom); end
        load_weights(rw);
        configure(2'b01, 2);
        run_window(3, 1'b1, five, 1'b0, rc, ex);
        tick();
        for (int l = 0; l < LN; l++) begin
            total++; if (Res_out[l*32 +: 32] !== ex[l][31:0]) begin bad++; $display("FAIL m01r_res lane%0d: got %h want %h", l, Res_out[l*32 +: 32], ex[l][31:0]); end
        end
        tick();
    endtask

    task automatic test_mode10();
        longint ex[LN];
        int iv[LN];
        int zc[LN] = '{0, 0, 0, 0};
        load_weights('{1, 2, 3, 4});
        configure(2'b10, 0);
        iv[0] = -3;
        for (int l = 1; l < LN; l++) iv[l] = int'($urandom_range(255)) - 128;
        W_en = 1'b1; W_in = 8'd7;
        run_window(1, 1'b0, iv, 1'b1, zc, ex);
        W_en = 1'b0;
        for (int l = LN - 1; l > 0; l--) wt[l] = wt[l-1];
        wt[0] = 7;
        total++; if (W_out !== wt[LN-1][7:0]) begin bad++; $display("FAIL m10_wout: got %0d want %0d", W_out, wt[LN-1]); end
        tick();
        total++; if (Res_valid !== 1'b1) begin bad++; $display("FAIL m10_valid: got %b want 1", Res_valid); end
        for (int l = 0; l < LN; l++) begin
            total++; if (Res_out[l*32 +: 32] !== 32'(-3 * (l + 1))) begin bad++; $display("FAIL m10_res lane%0d: got %0d want %0d", l, $signed(Res_out[l*32 +: 32]), -3 * (l + 1)); end
            total++; if (Res_out[l*32 +: 32] !== ex[l][31:0]) begin bad++; $display("FAIL m10_model lane%0d: got %h want %h", l, Res_out[l*32 +: 32], ex[l][31:0]); end
        end
        tick();
    endtask

    task automatic test_config_rewrite();
        longint ex[LN];
        logic [CW-1:0] word;
        int zc[LN] = '{0, 0, 0, 0};
        configure(2'b00, 2);
        I_in = $urandom; I_valid = 1'b1;
        tick();
        word = {2'b00, 8'd1};
        for (int k = CW - 1; k >= 0; k--) begin
            config_en = 1'b1;
            config_in = word[k];
            I_in = $urandom;
            cfg_q.push_back(word[k]);
            tick();
            total++; if (config_out !== cfg_q[cfg_q.size() - CW]) begin bad++; $display("FAIL cfg_out k%0d: got %b want %b", k, config_out, cfg_q[cfg_q.size() - CW]); end
            total++; if (Res_valid !== 1'b0) begin bad++; $display("FAIL cfg_shift_valid k%0d: got %b want 0", k, Res_valid); end
        end
        config_en = 1'b0;
        config_in = 1'b0;
        tick();
        I_valid = 1'b0;
        mode_m = 2'b00;
        acclen_m = 1;
        for (int k = 0; k < 3; k++) begin
            total++; if (Res_valid !== 1'b0) begin bad++; $display("FAIL cfg_abort_valid c%0d: got %b want 0", k, Res_valid); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL cfg_abort_busy c%0d: got %b want 0", k, busy); end
            tick();
        end
        run_window(2, 1'b1, zc, 1'b1, zc, ex);
        tick();
        total++; if (Res_valid !== 1'b1) begin bad++; $display("FAIL cfg_new_valid: got %b want 1", Res_valid); end
        for (int l = 0; l < LN; l++) begin
            total++; if (Res_out[l*32 +: 32] !== ex[l][31:0]) begin bad++; $display("FAIL cfg_new_res lane%0d: got %h want %h", l, Res_out[l*32 +: 32], ex[l][31:0]); end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        longint ex[5][LN];
        int iv[LN];
        int rc[LN];
        for (int l = 0; l < LN; l++) rc[l] = int'($urandom);
        configure(2'b11, 0);
        Res_cas_in_zero = 1'b0;
        for (int l = 0; l < LN; l++) Res_cas_in[l*32 +: 32] = rc[l];
        for (int c = 0; c < 7; c++) begin
            if (c < 5) begin
                for (int l = 0; l < LN; l++) iv[l] = int'($urandom_range(255)) - 128;
                I_in = pack_i(iv);
                I_valid = 1'b1;
                for (int l = 0; l < LN; l++) ex[c][l] = add_m(longint'(rc[l]), exp_prod(l, iv));
            end else begin
                I_valid = 1'b0;
            end
            tick();
            if (c >= 1 && c <= 5) begin
                total++; if (Res_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid c%0d: got %b want 1", c, Res_valid); end
                for (int l = 0; l < LN; l++) begin
                    total++; if (Res_out[l*32 +: 32] !== ex[c-1][l][31:0]) begin bad++; $display("FAIL b2b_res c%0d lane%0d: got %h want %h", c, l, Res_out[l*32 +: 32], ex[c-1][l][31:0]); end
                end
            end else begin
                total++; if (Res_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle c%0d: got %b want 0", c, Res_valid); end
            end
        end
    endtask

    task automatic test_max_window();
        longint ex[LN];
        int zc[LN] = '{0, 0, 0, 0};
        int rw[LN];
        for (int l = 0; l < LN; l++) rw[l] = int'($urandom_range(255)) - 128;
        load_weights(rw);
        configure(2'b00, 255);
        run_window(256, 1'b1, zc, 1'b1, zc, ex);
        total++; if (Res_valid !== 1'b0) begin bad++; $display("FAIL max_early: got %b want 0", Res_valid); end
        tick();
        total++; if (Res_valid !== 1'b1) begin bad++; $display("FAIL max_valid: got %b want 1", Res_valid); end
        for (int l = 0; l < LN; l++) begin
            total++; if (Res_out[l*32 +: 32] !== ex[l][31:0]) begin bad++; $display("FAIL max_res lane%0d: got %h want %h", l, Res_out[l*32 +: 32], ex[l][31:0]); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL max_wrap_busy: got %b want 0", busy); end
        tick();
    endtask

    task automatic test_overflow();
        longint ex[LN];
        int iv[LN] = '{127, 127, 127, 1};
        int cas[LN];
        cas[0] = 32'h7FFF_FFF0;
        cas[1] = 32'h0000_0000;
        cas[2] = 32'h8000_0005;
        cas[3] = 32'h7FFF_FFFF;
        load_weights('{127, 127, -128, 1});
        configure(2'b00, 1);
        run_window(2, 1'b0, iv, 1'b0, cas, ex);
        tick();
        total++; if (Res_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid: got %b want 1", Res_valid); end
        for (int l = 0; l < LN; l++) begin
            total++; if (Res_out[l*32 +: 32] !== ex[l][31:0]) begin bad++; $display("FAIL ovf_res lane%0d: got %h want %h", l, Res_out[l*32 +: 32], ex[l][31:0]); end
        end
        tick();
    endtask

    initial begin
        reset = 1'b0;
        config_en = 1'b0; config_in = 1'b0;
        I_in = 32'd0; I_valid = 1'b0;
        W_in = 8'd0; W_en = 1'b0;
        Res_cas_in = 128'd0; Res_cas_in_zero = 1'b0;
        model_reset();
        tick(); tick();
        test_reset();
        reset = 1'b1;
        tick();
        test_mode00();
        test_reset_mid_window();
        test_mode01();
        test_mode10();
        test_config_rewrite();
        test_back_to_back();
        test_max_window();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
